// File: rtl/icache_pkg.sv
// Shared geometry, FSM states and address helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINES_DEF = 4;
  localparam int WORDS_DEF = 4;
  localparam int BYTE_W    = 2;
  localparam int IDX_W     = $clog2(LINES_DEF);
  localparam int OFF_W     = $clog2(WORDS_DEF);
  localparam int TAG_W     = 32 - IDX_W - OFF_W - BYTE_W;
  localparam int LINE_W    = 32 * WORDS_DEF;

  typedef enum logic {
    IDLE,
    MISS
  } state_e;

  // Clears the word and byte offset so the refill always starts at word 0 of the line.
  function automatic logic [31:0] line_addr(input logic [31:0] pc);
    return {pc[31:OFF_W+BYTE_W], {(OFF_W+BYTE_W){1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: asynchronous read by index, synchronous whole-line write.
import icache_pkg::*;

module icache_line_store #(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [32*WORDS-1:0]   o_rd_data,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [32*WORDS-1:0]   i_wr_data
);

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [32*WORDS-1:0] r_data [LINES];

  // Only the valid bits need reset; stale tag/data behind a clear valid bit is harmless.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// IF-stage fetch controller: zero-latency hit path, single outstanding line refill on a miss.
import icache_pkg::*;

module icache_fetch #(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_pc,
  input  logic                i_pc_valid,
  input  logic                i_flush,
  output logic [31:0]         o_instr,
  output logic                o_instr_valid,
  output logic                o_stall,
  output logic                o_mem_req,
  output logic [31:0]         o_mem_addr,
  input  logic                i_mem_ready,
  input  logic [32*WORDS-1:0] i_mem_rdata
);

  state_e              r_state;
  state_e              w_next;
  logic                r_mem_req;
  logic [31:0]         r_mem_addr;
  logic                w_fill;
  logic                w_hit;
  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [32*WORDS-1:0] w_rd_data;
  logic [OFF_W-1:0]    w_word;
  logic                w_unused;

  assign w_unused = &{1'b0, i_pc[BYTE_W-1:0]};
  assign w_word   = i_pc[BYTE_W +: OFF_W];

  icache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_store (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_idx   (i_pc[BYTE_W+OFF_W +: IDX_W]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_fill),
    .i_wr_idx   (r_mem_addr[BYTE_W+OFF_W +: IDX_W]),
    .i_wr_tag   (r_mem_addr[31 -: TAG_W]),
    .i_wr_data  (i_mem_rdata)
  );

  assign w_hit = i_pc_valid && w_rd_valid && (w_rd_tag == i_pc[31 -: TAG_W]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A refill is never abandoned, so flush has no say in the state transitions.
  always_comb begin
    w_next = r_state;
    w_fill = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_pc_valid && !w_hit) begin
          w_next = MISS;
        end
      end
      MISS: begin
        if (i_mem_ready) begin
          w_next = IDLE;
          w_fill = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else if (r_state == IDLE && w_next == MISS) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= line_addr(i_pc);
    end else if (w_fill) begin
      r_mem_req  <= 1'b0;
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_instr       = w_hit ? w_rd_data[{w_word, 5'b0} +: 32] : 32'd0;
  assign o_instr_valid = (r_state == IDLE) && w_hit && !i_flush;
  // Held low during reset so the PC incrementer is never frozen by a cache being cleared.
  assign o_stall       = i_rst_n && (((r_state == IDLE) && i_pc_valid && !w_hit) || (r_state == MISS));

endmodule

// File: tb/tb_icache_fetch.sv
// Directed testbench for icache_fetch with hand-computed expectations.
module tb_icache_fetch;

  logic         clk;
  logic         rstN;
  logic [31:0]  pc;
  logic         pcValid;
  logic         flush;
  logic [31:0]  instr;
  logic         instrValid;
  logic         stall;
  logic         memReq;
  logic [31:0]  memAddr;
  logic         memReady;
  logic [127:0] memRdata;

  int checkCount;
  int errorCount;

  localparam logic [31:0] W0 = 32'hA000_0000;
  localparam logic [31:0] W1 = 32'hA111_1111;
  localparam logic [31:0] W2 = 32'hA222_2222;
  localparam logic [31:0] W3 = 32'hA333_3333;
  localparam logic [31:0] X0 = 32'hB000_0000;
  localparam logic [31:0] X1 = 32'hB111_1111;
  localparam logic [31:0] X2 = 32'hB222_2222;
  localparam logic [31:0] X3 = 32'hB333_3333;
  localparam logic [31:0] Y0 = 32'hC000_0000;
  localparam logic [31:0] Y1 = 32'hC111_1111;
  localparam logic [31:0] Y2 = 32'hC222_2222;
  localparam logic [31:0] Y3 = 32'hC333_3333;

  icache_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_pc          (pc),
    .i_pc_valid    (pcValid),
    .i_flush       (flush),
    .o_instr       (instr),
    .o_instr_valid (instrValid),
    .o_stall       (stall),
    .o_mem_req     (memReq),
    .o_mem_addr    (memAddr),
    .i_mem_ready   (memReady),
    .i_mem_rdata   (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge, then lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [31:0] addr, input logic fl,
                               input logic rdy, input logic [127:0] data);
    pcValid  = v;
    pc       = addr;
    flush    = fl;
    memReady = rdy;
    memRdata = data;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstN = 1'b0;
    applyStimulus(1'b1, 32'h3E4, 1'b0, 1'b0, '0);
    nextCycle();
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_ivalid", {31'd0, instrValid}, 32'd0);
    checkOutput("rst_req", {31'd0, memReq}, 32'd0);
    checkOutput("rst_addr", memAddr, 32'd0);

    // Cold miss at 0x3E4, data returned in N+3.
    rstN = 1'b1;
    applyStimulus(1'b1, 32'h3E4, 1'b0, 1'b0, '0);
    checkOutput("coldN_stall", {31'd0, stall}, 32'd1);
    checkOutput("coldN_req", {31'd0, memReq}, 32'd0);
    checkOutput("coldN_ivalid", {31'd0, instrValid}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      applyStimulus(1'b1, 32'h3E4, 1'b0, (c == 3), (c == 3) ? {W3, W2, W1, W0} : 128'd0);
      checkOutput("cold_stall", {31'd0, stall}, 32'd1);
      checkOutput("cold_req", {31'd0, memReq}, 32'd1);
      checkOutput("cold_addr", memAddr, 32'h3E0);
      checkOutput("cold_ivalid", {31'd0, instrValid}, 32'd0);
    end
    nextCycle();
    applyStimulus(1'b1, 32'h3E4, 1'b0, 1'b0, '0);
    checkOutput("fill_stall", {31'd0, stall}, 32'd0);
    checkOutput("fill_instr", instr, W1);
    checkOutput("fill_ivalid", {31'd0, instrValid}, 32'd1);
    checkOutput("fill_req", {31'd0, memReq}, 32'd0);

    // Sequential hits in the same line.
    nextCycle();
    applyStimulus(1'b1, 32'h3E8, 1'b0, 1'b0, '0);
    checkOutput("seq2_instr", instr, W2);
    checkOutput("seq2_stall", {31'd0, stall}, 32'd0);
    checkOutput("seq2_ivalid", {31'd0, instrValid}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h3EC, 1'b0, 1'b0, '0);
    checkOutput("seq3_instr", instr, W3);
    checkOutput("seq3_stall", {31'd0, stall}, 32'd0);

    // Flush on a hit squashes only instr_valid.
    nextCycle();
    applyStimulus(1'b1, 32'h3E8, 1'b1, 1'b0, '0);
    checkOutput("hitfl_ivalid", {31'd0, instrValid}, 32'd0);
    checkOutput("hitfl_stall", {31'd0, stall}, 32'd0);
    checkOutput("hitfl_instr", instr, W2);

    // pc_valid low: nothing happens even for an uncached address.
    nextCycle();
    applyStimulus(1'b0, 32'h900, 1'b0, 1'b0, '0);
    checkOutput("nov_stall", {31'd0, stall}, 32'd0);
    checkOutput("nov_ivalid", {31'd0, instrValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h3E4, 1'b0, 1'b1, {X3, X2, X1, X0});
    checkOutput("nov_req", {31'd0, memReq}, 32'd0);
    checkOutput("nov_ivalid2", {31'd0, instrValid}, 32'd0);

    // Conflict eviction: 0x7E4 shares index 2, minimum-penalty refill.
    nextCycle();
    applyStimulus(1'b1, 32'h7E4, 1'b0, 1'b0, '0);
    checkOutput("evN_stall", {31'd0, stall}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h7E4, 1'b0, 1'b1, {X3, X2, X1, X0});
    checkOutput("evN1_stall", {31'd0, stall}, 32'd1);
    checkOutput("evN1_addr", memAddr, 32'h7E0);
    nextCycle();
    applyStimulus(1'b1, 32'h7E4, 1'b0, 1'b0, '0);
    checkOutput("ev_instr", instr, X1);
    checkOutput("ev_ivalid", {31'd0, instrValid}, 32'd1);
    checkOutput("ev_stall", {31'd0, stall}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h3E4, 1'b0, 1'b0, '0);
    checkOutput("evback_stall", {31'd0, stall}, 32'd1);
    checkOutput("evback_ivalid", {31'd0, instrValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h3E4, 1'b0, 1'b1, {W3, W2, W1, W0});
    nextCycle();
    applyStimulus(1'b1, 32'h3E4, 1'b0, 1'b0, '0);
    checkOutput("evback_instr", instr, W1);

    // Flush while a refill is outstanding.
    nextCycle();
    applyStimulus(1'b1, 32'h014, 1'b0, 1'b0, '0);
    checkOutput("flN_stall", {31'd0, stall}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h014, 1'b1, 1'b0, '0);
    checkOutput("fl_req", {31'd0, memReq}, 32'd1);
    checkOutput("fl_ivalid", {31'd0, instrValid}, 32'd0);
    checkOutput("fl_stall", {31'd0, stall}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h014, 1'b0, 1'b1, {Y3, Y2, Y1, Y0});
    checkOutput("flhold_req", {31'd0, memReq}, 32'd1);
    checkOutput("flhold_addr", memAddr, 32'h010);
    nextCycle();
    applyStimulus(1'b1, 32'h018, 1'b0, 1'b0, '0);
    checkOutput("flnew_instr", instr, Y2);
    checkOutput("flnew_ivalid", {31'd0, instrValid}, 32'd1);
    checkOutput("flnew_req", {31'd0, memReq}, 32'd0);

    // Reset in the middle of a refill.
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, '0);
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, '0);
    checkOutput("mr_req", {31'd0, memReq}, 32'd1);
    checkOutput("mr_addr", memAddr, 32'h100);
    rstN = 1'b0;
    #1;
    checkOutput("mr_reqdrop", {31'd0, memReq}, 32'd0);
    checkOutput("mr_stall", {31'd0, stall}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, {Y3, Y2, Y1, Y0});
    nextCycle();
    rstN = 1'b1;
    applyStimulus(1'b0, 32'h104, 1'b0, 1'b1, {Y3, Y2, Y1, Y0});
    checkOutput("late_req", {31'd0, memReq}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, '0);
    checkOutput("post_stall", {31'd0, stall}, 32'd1);
    checkOutput("post_ivalid", {31'd0, instrValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, '0);
    checkOutput("post_req", {31'd0, memReq}, 32'd1);
    checkOutput("post_addr", memAddr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
